// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first.
// One full-subtractor cell, registered borrow, start/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // a_sh doubles as the result shifter: each consumed
    // minuend bit leaves room at the top for one result bit
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic x;
    logic y;
    logic d;
    logic br_nxt;
    logic accept;
    logic step;
    logic last;

    // full-subtractor cell on the current LSBs
    always_comb begin
        x      = a_sh[0];
        y      = b_sh[0];
        d      = x ^ y ^ br;
        br_nxt = (~x & y) | (~(x ^ y) & br);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state and datapath control
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // operand shifters, borrow and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (step) begin
            a_sh <= {d, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            br   <= br_nxt;
            if (!last) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // result registers, updated only on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (last) begin
            diff <= {d, a_sh[WIDTH-1:1]};
            bout <= br_nxt;
            ovf  <= (a_msb ^ b_msb) & (d ^ a_msb);
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor.
// Expected results come from a 9-bit arithmetic model.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int n_checks;
    int n_pass;
    res_t sb[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic bi);
        logic [W:0] f;
        res_t r;
        f = {1'b0, x} - {1'b0, y} - (W+1)'(bi);
        r.diff = f[W-1:0];
        r.bout = f[W];
        r.ovf  = (x[W-1] != y[W-1]) && (f[W-1] != x[W-1]);
        return r;
    endfunction

    // drive start in cycle 0; returns at the negedge of cycle 1
    task automatic launch(input logic [W-1:0] ai,
                          input logic [W-1:0] bi,
                          input logic bn);
        @(negedge clk);
        a     = ai;
        b     = bi;
        bin   = bn;
        start = 1'b1;
        sb.push_back(model(ai, bi, bn));
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
    endtask

    task automatic wait_done(input int cyc0, output int cyc,
                             output int busy_n, output bit both);
        cyc    = cyc0;
        busy_n = 0;
        while (!done && cyc < cyc0 + 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
        both = busy && done;
    endtask

    task automatic pop_exp(output res_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, diff, bout, ovf} !== '0)
            $display("FAIL reset_vals: got %b want 0",
                     {busy, done, diff, bout, ovf});
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00)
            $display("FAIL post_reset_idle: got %b want 00",
                     {busy, done});
        else n_pass++;
    endtask

    task automatic test_basic;
        int cyc, bn;
        bit both;
        res_t e;
        launch(8'h5A, 8'h3C, 1'b0);
        wait_done(1, cyc, bn, both);
        n_checks++;
        if (cyc !== 9)
            $display("FAIL basic_latency: got %0d want 9", cyc);
        else n_pass++;
        n_checks++;
        if (bn !== 8)
            $display("FAIL basic_busy_len: got %0d want 8", bn);
        else n_pass++;
        n_checks++;
        if (both !== 1'b0)
            $display("FAIL basic_busy_done: got 1 want 0");
        else n_pass++;
        pop_exp(e);
        n_checks++;
        if ({diff, bout, ovf} !== e)
            $display("FAIL basic_result: got %h/%b/%b want %h/%b/%b",
                     diff, bout, ovf, e.diff, e.bout, e.ovf);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00)
            $display("FAIL basic_done_pulse: got %b want 00",
                     {busy, done});
        else n_pass++;
    endtask

    task automatic test_table(input string name);
        logic [W-1:0] ta [4];
        logic [W-1:0] tb_ [4];
        logic         tc [4];
        int cyc, bn;
        bit both;
        res_t e;
        ta  = '{8'h00, 8'h80, 8'h10, 8'h00};
        tb_ = '{8'h01, 8'h01, 8'h0F, 8'hFF};
        tc  = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            launch(ta[i], tb_[i], tc[i]);
            wait_done(1, cyc, bn, both);
            pop_exp(e);
            n_checks++;
            if (cyc !== 9 || {diff, bout, ovf} !== e)
                $display("FAIL %s_%0d: got c%0d %h/%b/%b want c9 %h/%b/%b",
                         name, i, cyc, diff, bout, ovf,
                         e.diff, e.bout, e.ovf);
            else n_pass++;
        end
    endtask

    task automatic test_start_in_run;
        int cyc, bn, extra;
        bit both;
        res_t e;
        launch(8'h33, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, cyc, bn, both);
        pop_exp(e);
        n_checks++;
        if (cyc !== 9 || {diff, bout, ovf} !== e)
            $display("FAIL run_ignore: got c%0d %h/%b/%b want c9 %h/%b/%b",
                     cyc, diff, bout, ovf, e.diff, e.bout, e.ovf);
        else n_pass++;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        n_checks++;
        if (extra !== 0)
            $display("FAIL run_no_second: got %0d want 0", extra);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int cyc, bn, bad;
        bit both;
        res_t e;
        launch(8'h05, 8'h03, 1'b0);
        wait_done(1, cyc, bn, both);
        pop_exp(e);
        n_checks++;
        if (cyc !== 9 || {diff, bout, ovf} !== e)
            $display("FAIL b2b_first: got c%0d %h/%b/%b want c9 %h/%b/%b",
                     cyc, diff, bout, ovf, e.diff, e.bout, e.ovf);
        else n_pass++;
        a     = 8'h01;
        b     = 8'h02;
        bin   = 1'b0;
        start = 1'b1;
        sb.push_back(model(8'h01, 8'h02, 1'b0));
        @(negedge clk);
        start = 1'b0;
        bad   = 0;
        for (int k = 10; k < 18; k++) begin
            if (diff !== 8'h02 || done !== 1'b0 || busy !== 1'b1)
                bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0)
            $display("FAIL b2b_hold: got %0d bad cycles want 0", bad);
        else n_pass++;
        pop_exp(e);
        n_checks++;
        if (done !== 1'b1 || {diff, bout, ovf} !== e)
            $display("FAIL b2b_second: got d%b %h/%b/%b want d1 %h/%b/%b",
                     done, diff, bout, ovf, e.diff, e.bout, e.ovf);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        int cyc, bn, extra;
        bit both;
        res_t e;
        launch(8'hC3, 8'h11, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, diff, bout, ovf} !== '0)
            $display("FAIL rst_mid_async: got %b want 0",
                     {busy, done, diff, bout, ovf});
        else n_pass++;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy || diff !== '0) extra++;
        end
        n_checks++;
        if (extra !== 0)
            $display("FAIL rst_mid_idle: got %0d want 0", extra);
        else n_pass++;
        launch(8'h09, 8'h04, 1'b0);
        wait_done(1, cyc, bn, both);
        pop_exp(e);
        n_checks++;
        if (cyc !== 9 || {diff, bout, ovf} !== e)
            $display("FAIL rst_mid_fresh: got c%0d %h/%b/%b want c9 %h/%b/%b",
                     cyc, diff, bout, ovf, e.diff, e.bout, e.ovf);
        else n_pass++;
    endtask

    task automatic test_random;
        int cyc, bn;
        bit both;
        res_t e;
        for (int i = 0; i < 10; i++) begin
            launch(W'($urandom), W'($urandom), 1'($urandom));
            wait_done(1, cyc, bn, both);
            pop_exp(e);
            n_checks++;
            if (cyc !== 9 || both || {diff, bout, ovf} !== e)
                $display("FAIL rand_%0d: got c%0d %h/%b/%b want c9 %h/%b/%b",
                         i, cyc, diff, bout, ovf, e.diff, e.bout, e.ovf);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        bin      = 1'b0;
        test_reset();
        test_basic();
        test_table("tbl");
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
